// File: rtl/obf_key_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : obf_key_loader_if
// Brief    : Byte-stream handshake from the secure key store to the loader.
// Revision : 1.0
// ============================================================================
interface obf_key_loader_if;
  logic       key_in_valid;
  logic [7:0] key_in_data;
  logic       key_in_ready;

  modport master (
    output key_in_valid,
    output key_in_data,
    input  key_in_ready
  );

  modport slave (
    input  key_in_valid,
    input  key_in_data,
    output key_in_ready
  );
endinterface
`default_nettype wire

// File: rtl/obf_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : obf_key_loader
// Brief    : Loads an unlock key byte-stream, verifies its XOR checksum and
//            drives locking_key / gates ap_start into the locked block.
// Revision : 1.0
// ============================================================================
module obf_key_loader #(
  parameter int KEY_WIDTH = 255,
  parameter int NBYTES    = (KEY_WIDTH + 7) / 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 key_load,
  input  logic                 key_clear,
  obf_key_loader_if.slave      key_in,
  output logic [KEY_WIDTH-1:0] locking_key,
  output logic                 key_valid,
  output logic                 key_error,
  output logic                 busy,
  input  logic                 ap_start_in,
  output logic                 ap_start_out
);

  localparam int               CNT_W    = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_READY = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           csum_q, csum_d;
  logic                 match_q, match_d;
  logic                 key_valid_q, key_valid_d;
  logic                 key_error_q, key_error_d;
  logic [KEY_WIDTH-1:0] locking_key_q, locking_key_d;

  logic w_ready;
  logic w_take;

  // The byte on a key_clear cycle must never be consumed.
  assign w_ready = (state_q == S_LOAD) && !key_clear;
  assign w_take  = w_ready && key_in.key_in_valid;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    match_d  = match_q;
    if (key_clear) begin
      state_d  = S_IDLE;
      shadow_d = '0;
      cnt_d    = '0;
      csum_d   = '0;
      match_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_READY, S_ERROR: begin
          if (key_load) begin
            state_d  = S_LOAD;
            shadow_d = '0;
            cnt_d    = '0;
            csum_d   = '0;
            match_d  = 1'b0;
          end
        end
        S_LOAD: begin
          if (w_take) begin
            if (cnt_q == CNT_LAST) begin
              match_d = (key_in.key_in_data == csum_q);
              state_d = S_CHECK;
            end else begin
              // Bits beyond KEY_WIDTH have no home but still feed the checksum.
              for (int i = 0; i < KEY_WIDTH; i++) begin
                if (cnt_q == CNT_W'(i / 8)) shadow_d[i] = key_in.key_in_data[3'(i % 8)];
              end
              csum_d = csum_q ^ key_in.key_in_data;
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end
        end
        S_CHECK: begin
          if (match_q) begin
            state_d = S_READY;
          end else begin
            state_d  = S_ERROR;
            shadow_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status drops on the key_load/key_clear edge so an old key never overlaps a reload.
  always_comb begin
    key_valid_d   = (state_q == S_READY) && !key_load && !key_clear;
    key_error_d   = (state_q == S_ERROR) && !key_load && !key_clear;
    locking_key_d = key_valid_d ? shadow_q : '0;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      cnt_q         <= '0;
      csum_q        <= '0;
      match_q       <= 1'b0;
      key_valid_q   <= 1'b0;
      key_error_q   <= 1'b0;
      locking_key_q <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      match_q       <= match_d;
      key_valid_q   <= key_valid_d;
      key_error_q   <= key_error_d;
      locking_key_q <= locking_key_d;
    end
  end

  assign key_in.key_in_ready = w_ready;
  assign locking_key         = locking_key_q;
  assign key_valid           = key_valid_q;
  assign key_error           = key_error_q;
  assign busy                = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign ap_start_out        = ap_start_in && key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_obf_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_obf_key_loader
// Brief    : Directed self-checking bench for obf_key_loader.
// Revision : 1.0
// ============================================================================
module tb_obf_key_loader;
  localparam int KW = 255;
  localparam int NB = 32;

  logic          ap_clk      = 1'b0;
  logic          ap_rst_n    = 1'b0;
  logic          key_load    = 1'b0;
  logic          key_clear   = 1'b0;
  logic          ap_start_in = 1'b0;
  logic [KW-1:0] locking_key;
  logic          key_valid;
  logic          key_error;
  logic          busy;
  logic          ap_start_out;

  obf_key_loader_if kif ();

  obf_key_loader #(.KEY_WIDTH(KW), .NBYTES(NB)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .key_load     (key_load),
    .key_clear    (key_clear),
    .key_in       (kif),
    .locking_key  (locking_key),
    .key_valid    (key_valid),
    .key_error    (key_error),
    .busy         (busy),
    .ap_start_in  (ap_start_in),
    .ap_start_out (ap_start_out)
  );

  always #5 ap_clk = ~ap_clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] kb [NB];
  logic [KW-1:0] key_a;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [KW-1:0] build_key();
    logic [8*NB-1:0] v;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = kb[i];
    return v[KW-1:0];
  endfunction

  // Called at a negedge; returns at a negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_load);
    int w;
    kif.key_in_valid = 1'b1;
    kif.key_in_data  = b;
    key_load         = pulse_load;
    w = 0;
    #1;
    while (!kif.key_in_ready && w < 20) begin
      @(negedge ap_clk);
      #1;
      w++;
    end
    if (w >= 20) begin
      check("ready_timeout", 256'd0, 256'd1);
    end else begin
      @(negedge ap_clk);
    end
    kif.key_in_valid = 1'b0;
    key_load         = 1'b0;
    repeat (gap) @(negedge ap_clk);
  endtask

  task automatic start_load();
    key_load = 1'b1;
    @(negedge ap_clk);
    key_load = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] csum, input bit gaps, input int pulse_at);
    for (int i = 0; i < NB; i++)
      send_byte(kb[i], gaps ? int'($urandom_range(0, 5)) : 0, i == pulse_at);
    send_byte(csum, 0, 1'b0);
  endtask

  task automatic wait_result();
    repeat (2) @(negedge ap_clk);
    #1;
  endtask

  initial begin
    kif.key_in_valid = 1'b0;
    kif.key_in_data  = 8'h00;
    for (int i = 0; i < NB; i++) kb[i] = 8'(i + 1);
    key_a = build_key();

    // 1: reset, no load
    ap_start_in = 1'b1;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    #1;
    check("rst_key",     256'(locking_key), 256'd0);
    check("rst_kvalid",  256'(key_valid),   256'd0);
    check("rst_kerror",  256'(key_error),   256'd0);
    check("rst_busy",    256'(busy),        256'd0);
    check("rst_ready",   256'(kif.key_in_ready), 256'd0);
    check("rst_apstart", 256'(ap_start_out), 256'd0);

    // 2: good load, latency and byte placement
    start_load();
    #1 check("load_busy", 256'(busy), 256'd1);
    send_all(8'h20, 1'b0, -1);
    #1 check("lat_n0_kv", 256'(key_valid), 256'd0);
    @(negedge ap_clk);
    #1 check("lat_n1_kv", 256'(key_valid), 256'd0);
    @(negedge ap_clk);
    #1 check("lat_n2_kv", 256'(key_valid), 256'd1);
    check("key_full", 256'(locking_key), 256'(key_a));
    check("key_b0",   256'(locking_key[7:0]),     256'h01);
    check("key_b1",   256'(locking_key[15:8]),    256'h02);
    check("key_b31",  256'(locking_key[254:248]), 256'h20);
    check("ap_on",    256'(ap_start_out), 256'd1);
    ap_start_in = 1'b0;
    #1 check("ap_follow", 256'(ap_start_out), 256'd0);
    ap_start_in = 1'b1;

    // 3: bad checksum
    @(negedge ap_clk);
    start_load();
    send_all(8'h21, 1'b0, -1);
    wait_result();
    check("err_flag",  256'(key_error),    256'd1);
    check("err_kv",    256'(key_valid),    256'd0);
    check("err_key",   256'(locking_key),  256'd0);
    check("err_ap",    256'(ap_start_out), 256'd0);

    // 4: random stalls between bytes
    start_load();
    #1 check("reload_clr_err", 256'(key_error), 256'd0);
    send_all(8'h20, 1'b1, -1);
    wait_result();
    check("gap_kv",  256'(key_valid),   256'd1);
    check("gap_key", 256'(locking_key), 256'(key_a));

    // 5a: key_load mid-stream is ignored
    start_load();
    send_all(8'h20, 1'b0, 10);
    wait_result();
    check("midload_kv",  256'(key_valid),   256'd1);
    check("midload_key", 256'(locking_key), 256'(key_a));

    // 5b: key_clear at byte 20 with a byte presented
    start_load();
    for (int i = 0; i < 20; i++) send_byte(kb[i], 0, 1'b0);
    kif.key_in_valid = 1'b1;
    kif.key_in_data  = kb[20];
    key_clear        = 1'b1;
    #1 check("clr_ready", 256'(kif.key_in_ready), 256'd0);
    @(negedge ap_clk);
    key_clear = 1'b0;
    #1;
    check("clr_busy",  256'(busy),              256'd0);
    check("clr_ready2", 256'(kif.key_in_ready), 256'd0);
    check("clr_kv",    256'(key_valid),         256'd0);
    check("clr_key",   256'(locking_key),       256'd0);
    @(negedge ap_clk);
    #1 check("clr_idle_ready", 256'(kif.key_in_ready), 256'd0);
    kif.key_in_valid = 1'b0;
    start_load();
    send_all(8'h20, 1'b0, -1);
    wait_result();
    check("after_clr_key", 256'(locking_key), 256'(key_a));

    // 6: reload from READY; discarded top bit
    key_load = 1'b1;
    #1 check("pre_edge_kv", 256'(key_valid), 256'd1);
    @(negedge ap_clk);
    key_load = 1'b0;
    #1 check("reload_kv_drop", 256'(key_valid),    256'd0);
    check("reload_ap",        256'(ap_start_out),  256'd0);
    kb[31] = 8'hFF;
    for (int i = 0; i < NB; i++) begin
      send_byte(kb[i], 0, 1'b0);
      if (i == 16) check("reload_kv_mid", 256'(key_valid), 256'd0);
    end
    send_byte(8'hFF, 0, 1'b0);
    #1 check("reload_kv_chk", 256'(key_valid), 256'd0);
    wait_result();
    check("ff_kv",  256'(key_valid),             256'd1);
    check("ff_b31", 256'(locking_key[254:248]),  256'h7F);
    kb[31] = 8'h7F;
    start_load();
    send_all(8'h7F, 1'b0, -1);
    wait_result();
    check("7f_kv",  256'(key_valid),             256'd1);
    check("7f_b31", 256'(locking_key[254:248]),  256'h7F);
    check("7f_key", 256'(locking_key), 256'(build_key()));

    // 7: reset mid-load loses progress
    start_load();
    for (int i = 0; i < 5; i++) send_byte(kb[i], 0, 1'b0);
    ap_rst_n = 1'b0;
    #2;
    check("rst_mid_busy", 256'(busy),      256'd0);
    check("rst_mid_kv",   256'(key_valid), 256'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1 check("rst_mid_ready", 256'(kif.key_in_ready), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
